// File: rtl/mtr_pwm_drv.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module   : mtr_pwm_drv
// Brief    : Slew-limited sign/magnitude PWM drive for left and right H-bridges.
// Revision : 1.0 - initial release
// -----------------------------------------------------------------------------
module mtr_pwm_drv #(
    parameter int CNT_W     = 11,
    parameter int SLEW_STEP = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic signed [10:0] lft_spd,
    input  logic signed [10:0] rght_spd,
    output logic               lft_fwd_pwm,
    output logic               lft_rev_pwm,
    output logic               rght_fwd_pwm,
    output logic               rght_rev_pwm,
    output logic               frm_strt
);

    localparam logic [CNT_W-1:0]   c_cnt_last = {CNT_W{1'b1}};
    localparam logic signed [11:0] c_step     = 12'(SLEW_STEP);

    function automatic logic signed [10:0] slew_next(
        input logic signed [10:0] app,
        input logic signed [10:0] tgt
    );
        logic signed [11:0] app_x;
        logic signed [11:0] tgt_x;
        logic signed [11:0] diff;
        logic signed [11:0] nxt;
        app_x = {app[10], app};
        tgt_x = {tgt[10], tgt};
        diff  = tgt_x - app_x;
        if (diff > c_step) begin
            nxt = app_x + c_step;
        end else if (diff < -c_step) begin
            nxt = app_x - c_step;
        end else begin
            nxt = tgt_x;
        end
        // A reversal parks on zero for one whole frame before the new direction.
        if ((app != '0) && (nxt != '0) && (nxt[11] != app[10])) begin
            nxt = '0;
        end
        return nxt[10:0];
    endfunction

    function automatic logic [9:0] mag_of(input logic signed [10:0] app);
        if (!app[10]) begin
            return app[9:0];
        end
        if (app[9:0] == '0) begin
            return 10'h3FF;
        end
        return 10'(~app[9:0] + 10'd1);
    endfunction

    logic [CNT_W-1:0]   cnt_q;
    logic signed [10:0] lft_app_q;
    logic signed [10:0] lft_app_d;
    logic signed [10:0] rght_app_q;
    logic signed [10:0] rght_app_d;
    logic               lft_fwd_q;
    logic               lft_rev_q;
    logic               rght_fwd_q;
    logic               rght_rev_q;
    logic               frm_strt_q;

    logic [9:0]         cmp_pos;
    logic [9:0]         lft_mag;
    logic [9:0]         rght_mag;
    logic               lft_on;
    logic               rght_on;

    assign cmp_pos  = cnt_q[CNT_W-1 -: 10];
    assign lft_mag  = mag_of(lft_app_q);
    assign rght_mag = mag_of(rght_app_q);
    assign lft_on   = (cmp_pos < lft_mag);
    assign rght_on  = (cmp_pos < rght_mag);

    // Applied speeds only move on the last count of a frame, so duty never changes mid-frame.
    always_comb begin
        lft_app_d  = lft_app_q;
        rght_app_d = rght_app_q;
        if (!en) begin
            lft_app_d  = '0;
            rght_app_d = '0;
        end else if (cnt_q == c_cnt_last) begin
            lft_app_d  = slew_next(lft_app_q, lft_spd);
            rght_app_d = slew_next(rght_app_q, rght_spd);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            lft_app_q  <= '0;
            rght_app_q <= '0;
            lft_fwd_q  <= 1'b0;
            lft_rev_q  <= 1'b0;
            rght_fwd_q <= 1'b0;
            rght_rev_q <= 1'b0;
            frm_strt_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_q + CNT_W'(1);
            lft_app_q  <= lft_app_d;
            rght_app_q <= rght_app_d;
            frm_strt_q <= (cnt_q == '0);
            lft_fwd_q  <= en & lft_on & ~lft_app_q[10] & (lft_mag != '0);
            lft_rev_q  <= en & lft_on & lft_app_q[10];
            rght_fwd_q <= en & rght_on & ~rght_app_q[10] & (rght_mag != '0);
            rght_rev_q <= en & rght_on & rght_app_q[10];
        end
    end

    assign lft_fwd_pwm  = lft_fwd_q;
    assign lft_rev_pwm  = lft_rev_q;
    assign rght_fwd_pwm = rght_fwd_q;
    assign rght_rev_pwm = rght_rev_q;
    assign frm_strt     = frm_strt_q;

endmodule
`default_nettype wire

// File: tb/tb_mtr_pwm_drv.sv
`default_nettype none
// Bench for mtr_pwm_drv: per-cycle scoreboard against a behavioural model plus frame-level duty checks.
// A second instance with a coarse slew step reaches full-scale and mid-scale speeds in few frames.
module tb_mtr_pwm_drv;

    localparam int FRM = 2048;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en0 = 1'b1;
    logic               en1 = 1'b1;
    logic signed [10:0] lspd0 = '0;
    logic signed [10:0] rspd0 = '0;
    logic signed [10:0] lspd1 = '0;
    logic signed [10:0] rspd1 = '0;
    logic               lf0, lr0, rf0, rr0, fs0;
    logic               lf1, lr1, rf1, rr1, fs1;

    int                 total = 0;
    int                 bad   = 0;
    logic [4:0]         q0[$];
    logic [4:0]         q1[$];
    logic [4:0]         exp0;
    logic [4:0]         exp1;
    int                 m_cnt [2];
    int                 m_l   [2];
    int                 m_r   [2];

    always #5 clk = ~clk;

    mtr_pwm_drv #(.CNT_W(11), .SLEW_STEP(16)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en0),
        .lft_spd      (lspd0),
        .rght_spd     (rspd0),
        .lft_fwd_pwm  (lf0),
        .lft_rev_pwm  (lr0),
        .rght_fwd_pwm (rf0),
        .rght_rev_pwm (rr0),
        .frm_strt     (fs0)
    );

    mtr_pwm_drv #(.CNT_W(11), .SLEW_STEP(128)) u_dut_fast (
        .clk          (clk),
        .rst          (rst),
        .en           (en1),
        .lft_spd      (lspd1),
        .rght_spd     (rspd1),
        .lft_fwd_pwm  (lf1),
        .lft_rev_pwm  (lr1),
        .rght_fwd_pwm (rf1),
        .rght_rev_pwm (rr1),
        .frm_strt     (fs1)
    );

    function automatic int m_slew(int app, int tgt, int step);
        int n;
        if (tgt - app > step) n = app + step;
        else if (tgt - app < -step) n = app - step;
        else n = tgt;
        if ((app > 0 && n < 0) || (app < 0 && n > 0)) n = 0;
        return n;
    endfunction

    function automatic int m_mag(int app);
        if (app < 0) return (app == -1024) ? 1023 : -app;
        return app;
    endfunction

    // Advances both models by one clock and queues the outputs each DUT must show after this edge.
    task automatic model_step();
        logic [4:0] e;
        logic       ena;
        int         step, lt, rt, ml, mr, pos;
        for (int k = 0; k < 2; k++) begin
            step = (k == 0) ? 16 : 128;
            ena  = (k == 0) ? en0 : en1;
            lt   = (k == 0) ? int'(lspd0) : int'(lspd1);
            rt   = (k == 0) ? int'(rspd0) : int'(rspd1);
            if (rst) begin
                m_cnt[k] = 0;
                m_l[k]   = 0;
                m_r[k]   = 0;
                e        = '0;
            end else begin
                ml   = m_mag(m_l[k]);
                mr   = m_mag(m_r[k]);
                pos  = m_cnt[k] / 2;
                e[4] = ena && (m_l[k] > 0) && (pos < ml);
                e[3] = ena && (m_l[k] < 0) && (pos < ml);
                e[2] = ena && (m_r[k] > 0) && (pos < mr);
                e[1] = ena && (m_r[k] < 0) && (pos < mr);
                e[0] = (m_cnt[k] == 0);
                if (!ena) begin
                    m_l[k] = 0;
                    m_r[k] = 0;
                end else if (m_cnt[k] == FRM - 1) begin
                    m_l[k] = m_slew(m_l[k], lt, step);
                    m_r[k] = m_slew(m_r[k], rt, step);
                end
                m_cnt[k] = (m_cnt[k] + 1) % FRM;
            end
            if (k == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        exp0 = q0.pop_front();
        exp1 = q1.pop_front();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            total += 3;
            if ({lf0, lr0, rf0, rr0, fs0} !== exp0) begin bad++; $display("FAIL reset_model0 t=%0t got=%b exp=%b", $time, {lf0, lr0, rf0, rr0, fs0}, exp0); end
            if ({lf1, lr1, rf1, rr1, fs1} !== exp1) begin bad++; $display("FAIL reset_model1 t=%0t got=%b exp=%b", $time, {lf1, lr1, rf1, rr1, fs1}, exp1); end
            if ({lf0, lr0, rf0, rr0, fs0, lf1, lr1, rf1, rr1, fs1} !== 10'h0) begin
                bad++; $display("FAIL reset_state t=%0t got=%b exp=0", $time, {lf0, lr0, rf0, rr0, fs0, lf1, lr1, rf1, rr1, fs1});
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            total += 3;
            if ({lf0, lr0, rf0, rr0, fs0} !== exp0) begin bad++; $display("FAIL reset_model0 t=%0t got=%b exp=%b", $time, {lf0, lr0, rf0, rr0, fs0}, exp0); end
            if ({lf1, lr1, rf1, rr1, fs1} !== exp1) begin bad++; $display("FAIL reset_model1 t=%0t got=%b exp=%b", $time, {lf1, lr1, rf1, rr1, fs1}, exp1); end
            if ({lf0, lr0, rf0, rr0, fs0} !== {4'b0, (i == 0) ? 1'b1 : 1'b0}) begin
                bad++; $display("FAIL first_frm_strt cycle=%0d got=%b exp=%b", i, {lf0, lr0, rf0, rr0, fs0}, {4'b0, (i == 0) ? 1'b1 : 1'b0});
            end
        end
    endtask

    task automatic test_ramp();
        int f, hi, rv;
        int exp_hi [7];
        exp_hi = '{32, 64, 96, 128, 160, 192, 200};
        lspd0 = 11'sd100;
        rspd0 = -11'sd200;
        lspd1 = 11'sd500;
        rspd1 = -11'sd1024;
        f = -1; hi = 0; rv = 0;
        for (int i = 0; i < 9 * FRM && f < 7; i++) begin
            cyc();
            total += 2;
            if ({lf0, lr0, rf0, rr0, fs0} !== exp0) begin bad++; $display("FAIL ramp_model0 t=%0t got=%b exp=%b", $time, {lf0, lr0, rf0, rr0, fs0}, exp0); end
            if ({lf1, lr1, rf1, rr1, fs1} !== exp1) begin bad++; $display("FAIL ramp_model1 t=%0t got=%b exp=%b", $time, {lf1, lr1, rf1, rr1, fs1}, exp1); end
            if (fs0) begin
                if (f >= 0) begin
                    total++;
                    if (hi !== exp_hi[f] || rv !== 0) begin
                        bad++; $display("FAIL ramp_duty frame=%0d fwd=%0d rev=%0d exp_fwd=%0d exp_rev=0", f, hi, rv, exp_hi[f]);
                    end
                end
                f++; hi = 0; rv = 0;
            end
            hi += int'(lf0);
            rv += int'(lr0);
        end
        if (f < 7) begin total++; bad++; $display("FAIL ramp_timeout frames=%0d exp=7", f); end
    endtask

    task automatic test_zero_cross();
        int g, hi, rv;
        int exp_hi [7];
        int exp_rv [7];
        exp_hi = '{80, 48, 16, 0, 0, 0, 0};
        exp_rv = '{0, 0, 0, 0, 32, 64, 80};
        lspd0 = 11'sd40;
        g = 0; hi = 0; rv = 0;
        for (int i = 0; i < 13 * FRM && g < 11; i++) begin
            cyc();
            total += 2;
            if ({lf0, lr0, rf0, rr0, fs0} !== exp0) begin bad++; $display("FAIL zc_model0 t=%0t got=%b exp=%b", $time, {lf0, lr0, rf0, rr0, fs0}, exp0); end
            if ({lf1, lr1, rf1, rr1, fs1} !== exp1) begin bad++; $display("FAIL zc_model1 t=%0t got=%b exp=%b", $time, {lf1, lr1, rf1, rr1, fs1}, exp1); end
            if (fs0) begin
                if (g >= 4) begin
                    total++;
                    if (hi !== exp_hi[g-4] || rv !== exp_rv[g-4]) begin
                        bad++; $display("FAIL zc_duty frame=%0d fwd=%0d rev=%0d exp_fwd=%0d exp_rev=%0d", g, hi, rv, exp_hi[g-4], exp_rv[g-4]);
                    end
                end
                g++; hi = 0; rv = 0;
                if (g == 4) lspd0 = -11'sd40;
            end
            hi += int'(lf0);
            rv += int'(lr0);
        end
        if (g < 11) begin total++; bad++; $display("FAIL zc_timeout frames=%0d exp=11", g); end
    endtask

    task automatic test_cmd_sampling();
        logic pf, pr;
        pf = lf0;
        pr = lr0;
        for (int i = 0; i < 3 * FRM; i++) begin
            if (i % 100 == 0) lspd0 = (lspd0 == 11'sd300) ? 11'sd0 : 11'sd300;
            cyc();
            total += 2;
            if ({lf0, lr0, rf0, rr0, fs0} !== exp0) begin bad++; $display("FAIL sample_model0 t=%0t got=%b exp=%b", $time, {lf0, lr0, rf0, rr0, fs0}, exp0); end
            if ({lf1, lr1, rf1, rr1, fs1} !== exp1) begin bad++; $display("FAIL sample_model1 t=%0t got=%b exp=%b", $time, {lf1, lr1, rf1, rr1, fs1}, exp1); end
            if ((lf0 && !pf) || (lr0 && !pr)) begin
                total++;
                if (fs0 !== 1'b1) begin bad++; $display("FAIL mid_frame_rise t=%0t frm_strt=%b exp=1", $time, fs0); end
            end
            pf = lf0;
            pr = lr0;
        end
        lspd0 = 11'sd300;
    endtask

    task automatic test_full_reverse();
        int g, lh, lv, rh, rv;
        g = -1; lh = 0; lv = 0; rh = 0; rv = 0;
        for (int i = 0; i < 4 * FRM && g < 2; i++) begin
            cyc();
            total += 2;
            if ({lf0, lr0, rf0, rr0, fs0} !== exp0) begin bad++; $display("FAIL fullrev_model0 t=%0t got=%b exp=%b", $time, {lf0, lr0, rf0, rr0, fs0}, exp0); end
            if ({lf1, lr1, rf1, rr1, fs1} !== exp1) begin bad++; $display("FAIL fullrev_model1 t=%0t got=%b exp=%b", $time, {lf1, lr1, rf1, rr1, fs1}, exp1); end
            if (fs1) begin
                if (g >= 0) begin
                    total += 2;
                    if (rv !== 2046 || rh !== 0) begin bad++; $display("FAIL full_reverse frame=%0d rev=%0d fwd=%0d exp_rev=2046 exp_fwd=0", g, rv, rh); end
                    if (lh !== 1000 || lv !== 0) begin bad++; $display("FAIL mid_forward frame=%0d fwd=%0d rev=%0d exp_fwd=1000 exp_rev=0", g, lh, lv); end
                end
                g++; lh = 0; lv = 0; rh = 0; rv = 0;
            end
            lh += int'(lf1); lv += int'(lr1);
            rh += int'(rf1); rv += int'(rr1);
        end
        if (g < 2) begin total++; bad++; $display("FAIL fullrev_timeout frames=%0d exp=2", g); end
    endtask

    task automatic test_enable();
        int g, l0, r0, l1, r1;
        for (int i = 0; i < 100; i++) begin
            cyc();
            total += 2;
            if ({lf0, lr0, rf0, rr0, fs0} !== exp0) begin bad++; $display("FAIL en_model0 t=%0t got=%b exp=%b", $time, {lf0, lr0, rf0, rr0, fs0}, exp0); end
            if ({lf1, lr1, rf1, rr1, fs1} !== exp1) begin bad++; $display("FAIL en_model1 t=%0t got=%b exp=%b", $time, {lf1, lr1, rf1, rr1, fs1}, exp1); end
        end
        total++;
        if (lf1 !== 1'b1) begin bad++; $display("FAIL en_pre_drop fwd=%b exp=1", lf1); end
        en0 = 1'b0;
        en1 = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            total += 3;
            if ({lf0, lr0, rf0, rr0, fs0} !== exp0) begin bad++; $display("FAIL en_model0 t=%0t got=%b exp=%b", $time, {lf0, lr0, rf0, rr0, fs0}, exp0); end
            if ({lf1, lr1, rf1, rr1, fs1} !== exp1) begin bad++; $display("FAIL en_model1 t=%0t got=%b exp=%b", $time, {lf1, lr1, rf1, rr1, fs1}, exp1); end
            if ({lf0, lr0, rf0, rr0, lf1, lr1, rf1, rr1} !== 8'h00) begin
                bad++; $display("FAIL en_off cycle=%0d got=%b exp=00000000", i, {lf0, lr0, rf0, rr0, lf1, lr1, rf1, rr1});
            end
        end
        en0 = 1'b1;
        en1 = 1'b1;
        g = -1; l0 = 0; r0 = 0; l1 = 0; r1 = 0;
        for (int i = 0; i < 3 * FRM && g < 1; i++) begin
            cyc();
            total += 3;
            if ({lf0, lr0, rf0, rr0, fs0} !== exp0) begin bad++; $display("FAIL en_model0 t=%0t got=%b exp=%b", $time, {lf0, lr0, rf0, rr0, fs0}, exp0); end
            if ({lf1, lr1, rf1, rr1, fs1} !== exp1) begin bad++; $display("FAIL en_model1 t=%0t got=%b exp=%b", $time, {lf1, lr1, rf1, rr1, fs1}, exp1); end
            if ((lf0 & lr0) | (rf0 & rr0) | (lf1 & lr1) | (rf1 & rr1)) begin
                bad++; $display("FAIL fwd_rev_overlap t=%0t got=%b exp=no overlap", $time, {lf0, lr0, rf0, rr0, lf1, lr1, rf1, rr1});
            end
            if (fs0) begin
                if (g == 0) begin
                    total += 2;
                    if (l0 !== 32 || r0 !== 32) begin bad++; $display("FAIL restart_step16 lfwd=%0d rrev=%0d exp=32/32", l0, r0); end
                    if (l1 !== 256 || r1 !== 256) begin bad++; $display("FAIL restart_step128 lfwd=%0d rrev=%0d exp=256/256", l1, r1); end
                end
                g++; l0 = 0; r0 = 0; l1 = 0; r1 = 0;
            end
            l0 += int'(lf0); r0 += int'(rr0);
            l1 += int'(lf1); r1 += int'(rr1);
        end
        if (g < 1) begin total++; bad++; $display("FAIL restart_timeout frames=%0d exp=1", g); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_zero_cross();
        test_cmd_sampling();
        test_full_reverse();
        test_enable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
